countdown_timer: RTL and testbench

Minutes:seconds down-counter, the decrementing counterpart of the team's mod-60 seconds counter. It loads a preset up to MAX_MIN:59 and counts down once per second, using a prescaler off `clk`. On reaching 00:00 it raises a one-cycle `done` pulse and a held `expired` flag. It sits beside the up-counter in the timekeeping path and feeds the display/alarm logic.

---
 rtl/countdown_timer.sv | 166 ++++++++++++++++
 tb/tb_countdown_timer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Minutes:seconds down-counter with a one-second prescaler, one-cycle done pulse and held expired flag.
// Optional build macro COUNTDOWN_AUTO_RELOAD_EN reloads the preset on expiry and keeps counting.
module countdown_timer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int MAX_MIN  = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       start,
    input  logic       pause,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [5:0]    MAX_MIN_V = 6'(MAX_MIN);
    localparam logic [5:0]    SEC_TOP   = 6'd59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t        state_r, state_nx_s;
    logic [PW-1:0] presc_r, presc_nx_s;
    logic [5:0]    min_nx_s, sec_nx_s;
    logic          done_nx_s;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [5:0]    preset_min_r, preset_sec_r;
`endif

    function automatic logic [5:0] clamp_sec(input logic [5:0] v);
        if (v > SEC_TOP) clamp_sec = SEC_TOP;
        else             clamp_sec = v;
    endfunction

    function automatic logic [5:0] clamp_min(input logic [5:0] v);
        if (v > MAX_MIN_V) clamp_min = MAX_MIN_V;
        else               clamp_min = v;
    endfunction

    // Next-state, next-value and done-pulse decode; load outranks pause, pause outranks start.
    always_comb begin
        state_nx_s = state_r;
        presc_nx_s = presc_r;
        min_nx_s   = min;
        sec_nx_s   = sec;
        done_nx_s  = 1'b0;
        if (load) begin
            state_nx_s = IDLE;
            presc_nx_s = '0;
            min_nx_s   = clamp_min(load_min);
            sec_nx_s   = clamp_sec(load_sec);
        end else begin
            case (state_r)
                IDLE: begin
                    if (pause) begin
                        state_nx_s = IDLE;
                    end else if (start) begin
                        presc_nx_s = '0;
                        if (min == 6'd0 && sec == 6'd0) begin
                            state_nx_s = EXPIRED;
                            done_nx_s  = 1'b1;
                        end else begin
                            state_nx_s = RUN;
                        end
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_nx_s = PAUSE;
                    end else if (presc_r == TICK_LAST) begin
                        presc_nx_s = '0;
                        if (sec != 6'd0) begin
                            sec_nx_s = sec - 6'd1;
                        end else if (min != 6'd0) begin
                            sec_nx_s = SEC_TOP;
                            min_nx_s = min - 6'd1;
                        end else begin
                            sec_nx_s = 6'd0;
                        end
                        // This tick lands on (or already sits at) 00:00.
                        if (min == 6'd0 && sec <= 6'd1) begin
                            done_nx_s = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            if (preset_min_r != 6'd0 || preset_sec_r != 6'd0) begin
                                min_nx_s   = preset_min_r;
                                sec_nx_s   = preset_sec_r;
                                state_nx_s = RUN;
                            end else begin
                                state_nx_s = EXPIRED;
                            end
`else
                            state_nx_s = EXPIRED;
`endif
                        end else begin
                            state_nx_s = RUN;
                        end
                    end else begin
                        presc_nx_s = presc_r + PW'(1);
                    end
                end
                PAUSE: begin
                    if (!pause && start) state_nx_s = RUN;
                    else                 state_nx_s = PAUSE;
                end
                EXPIRED: begin
                    state_nx_s = EXPIRED;
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // State, prescaler and registered outputs, all cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            presc_r <= '0;
            min     <= 6'd0;
            sec     <= 6'd0;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            presc_r <= presc_nx_s;
            min     <= min_nx_s;
            sec     <= sec_nx_s;
            running <= (state_nx_s == RUN);
            done    <= done_nx_s;
            expired <= (state_nx_s == EXPIRED);
        end
    end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    // Preset captured on every load for reload after expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            preset_min_r <= 6'd0;
            preset_sec_r <= 6'd0;
        end else if (load) begin
            preset_min_r <= clamp_min(load_min);
            preset_sec_r <= clamp_sec(load_sec);
        end else begin
            preset_min_r <= preset_min_r;
            preset_sec_r <= preset_sec_r;
        end
    end
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer at TICK_DIV=4; expected outputs are queued as each cycle's stimulus is driven.
// Expiry checks follow the build: COUNTDOWN_AUTO_RELOAD_EN selects the reload scenario instead of the stop-in-EXPIRED one.
module tb_countdown_timer;

    logic       clk;
    logic       rst, load, start, pause;
    logic [5:0] load_min, load_sec;
    logic [5:0] min, sec;
    logic       running, done, expired;

    int          checks = 0;
    int          errors = 0;
    logic [14:0] sb[$];
    logic [14:0] got, want;

    countdown_timer #(.TICK_DIV(4), .MAX_MIN(59)) dut (
        .clk(clk), .rst(rst), .load(load), .load_min(load_min), .load_sec(load_sec),
        .start(start), .pause(pause), .min(min), .sec(sec),
        .running(running), .done(done), .expired(expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic drive(input logic r, input logic ld, input logic [5:0] lm, input logic [5:0] ls,
                         input logic st, input logic pa,
                         input logic [5:0] em, input logic [5:0] es,
                         input logic er, input logic ed, input logic ee);
        rst = r; load = ld; load_min = lm; load_sec = ls; start = st; pause = pa;
        sb.push_back({em, es, er, ed, ee});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, (c == 1), 6'd5, 6'd5, (c == 1), 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
            step();
            want = sb.pop_front(); got = {min, sec, running, done, expired}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset c%0d: got %0d:%0d r%b d%b e%b want %0d:%0d r%b d%b e%b", c,
                         got[14:9], got[8:3], got[2], got[1], got[0], want[14:9], want[8:3], want[2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_count();
        int k, tot;
        for (int c = 0; c < 14; c++) begin
            if (c == 0) drive(1'b0, 1'b1, 6'd1, 6'd2, 1'b0, 1'b0, 6'd1, 6'd2, 1'b0, 1'b0, 1'b0);
            else if (c == 1) drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd1, 6'd2, 1'b1, 1'b0, 1'b0);
            else begin
                k = c - 1;
                tot = 62 - k / 4;
                drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'(tot / 60), 6'(tot % 60), 1'b1, 1'b0, 1'b0);
            end
            step();
            want = sb.pop_front(); got = {min, sec, running, done, expired}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL count c%0d: got %0d:%0d r%b d%b e%b want %0d:%0d r%b d%b e%b", c,
                         got[14:9], got[8:3], got[2], got[1], got[0], want[14:9], want[8:3], want[2], want[1], want[0]);
            end
        end
    endtask

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    task automatic test_expire();
        int k;
        logic [5:0] es;
        for (int c = 0; c < 14; c++) begin
            if (c == 0) drive(1'b0, 1'b1, 6'd0, 6'd2, 1'b0, 1'b0, 6'd0, 6'd2, 1'b0, 1'b0, 1'b0);
            else if (c == 1) drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd2, 1'b1, 1'b0, 1'b0);
            else begin
                k = c - 1;
                es = (k < 4) ? 6'd2 : ((k < 8) ? 6'd1 : 6'd0);
                drive(1'b0, 1'b0, 6'd0, 6'd0, (c == 10 || c == 12), (c == 11),
                      6'd0, es, (k < 8), (k == 8), (k >= 8));
            end
            step();
            want = sb.pop_front(); got = {min, sec, running, done, expired}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL expire c%0d: got %0d:%0d r%b d%b e%b want %0d:%0d r%b d%b e%b", c,
                         got[14:9], got[8:3], got[2], got[1], got[0], want[14:9], want[8:3], want[2], want[1], want[0]);
            end
        end
    endtask
`else
    task automatic test_auto_reload();
        int k, dec;
        for (int c = 0; c < 19; c++) begin
            if (c == 0) drive(1'b0, 1'b1, 6'd0, 6'd2, 1'b0, 1'b0, 6'd0, 6'd2, 1'b0, 1'b0, 1'b0);
            else if (c == 1) drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd2, 1'b1, 1'b0, 1'b0);
            else begin
                k = c - 1;
                dec = k / 4;
                drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, (dec % 2 == 0) ? 6'd2 : 6'd1,
                      1'b1, (k % 4 == 0 && dec % 2 == 0), 1'b0);
            end
            step();
            want = sb.pop_front(); got = {min, sec, running, done, expired}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reload c%0d: got %0d:%0d r%b d%b e%b want %0d:%0d r%b d%b e%b", c,
                         got[14:9], got[8:3], got[2], got[1], got[0], want[14:9], want[8:3], want[2], want[1], want[0]);
            end
        end
    endtask
`endif

    task automatic test_pause();
        int k;
        logic [5:0] es;
        logic er;
        for (int c = 0; c < 21; c++) begin
            if (c == 0) drive(1'b0, 1'b1, 6'd0, 6'd5, 1'b0, 1'b0, 6'd0, 6'd5, 1'b0, 1'b0, 1'b0);
            else if (c == 1) drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd5, 1'b1, 1'b0, 1'b0);
            else begin
                k = c - 1;
                er = !(k >= 3 && k <= 12);
                es = (k <= 14) ? 6'd5 : ((k <= 18) ? 6'd4 : 6'd3);
                drive(1'b0, 1'b0, 6'd0, 6'd0, (k == 13), (k >= 3 && k <= 12), 6'd0, es, er, 1'b0, 1'b0);
            end
            step();
            want = sb.pop_front(); got = {min, sec, running, done, expired}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL pause c%0d: got %0d:%0d r%b d%b e%b want %0d:%0d r%b d%b e%b", c,
                         got[14:9], got[8:3], got[2], got[1], got[0], want[14:9], want[8:3], want[2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_clamp_and_reload_mid_run();
        for (int c = 0; c < 10; c++) begin
            case (c)
                0: drive(1'b0, 1'b1, 6'd63, 6'd61, 1'b0, 1'b0, 6'd59, 6'd59, 1'b0, 1'b0, 1'b0);
                1: drive(1'b0, 1'b1, 6'd58, 6'd60, 1'b0, 1'b0, 6'd58, 6'd59, 1'b0, 1'b0, 1'b0);
                2: drive(1'b0, 1'b1, 6'd60, 6'd58, 1'b0, 1'b0, 6'd59, 6'd58, 1'b0, 1'b0, 1'b0);
                3: drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd59, 6'd58, 1'b1, 1'b0, 1'b0);
                4, 5: drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd59, 6'd58, 1'b1, 1'b0, 1'b0);
                6: drive(1'b0, 1'b1, 6'd10, 6'd30, 1'b1, 1'b1, 6'd10, 6'd30, 1'b0, 1'b0, 1'b0);
                default: drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd10, 6'd30, 1'b0, 1'b0, 1'b0);
            endcase
            step();
            want = sb.pop_front(); got = {min, sec, running, done, expired}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL clamp c%0d: got %0d:%0d r%b d%b e%b want %0d:%0d r%b d%b e%b", c,
                         got[14:9], got[8:3], got[2], got[1], got[0], want[14:9], want[8:3], want[2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_zero_start();
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: drive(1'b0, 1'b1, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
                1: drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
                2: drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
                default: drive(1'b0, 1'b1, 6'd0, 6'd1, 1'b0, 1'b0, 6'd0, 6'd1, 1'b0, 1'b0, 1'b0);
            endcase
            step();
            want = sb.pop_front(); got = {min, sec, running, done, expired}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL zero c%0d: got %0d:%0d r%b d%b e%b want %0d:%0d r%b d%b e%b", c,
                         got[14:9], got[8:3], got[2], got[1], got[0], want[14:9], want[8:3], want[2], want[1], want[0]);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        for (int c = 0; c < 11; c++) begin
            if (c == 0) drive(1'b0, 1'b1, 6'd0, 6'd3, 1'b0, 1'b0, 6'd0, 6'd3, 1'b0, 1'b0, 1'b0);
            else if (c == 1) drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd3, 1'b1, 1'b0, 1'b0);
            else if (c <= 4) drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd3, 1'b1, 1'b0, 1'b0);
            else if (c == 5) drive(1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
            else if (c < 10) drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
            else drive(1'b0, 1'b0, 6'd0, 6'd0, 1'b1, 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b1);
            step();
            want = sb.pop_front(); got = {min, sec, running, done, expired}; checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL rstmid c%0d: got %0d:%0d r%b d%b e%b want %0d:%0d r%b d%b e%b", c,
                         got[14:9], got[8:3], got[2], got[1], got[0], want[14:9], want[8:3], want[2], want[1], want[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; start = 1'b0; pause = 1'b0;
        load_min = 6'd0; load_sec = 6'd0;
        test_reset();
        test_count();
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        test_expire();
`else
        test_auto_reload();
`endif
        test_pause();
        test_clamp_and_reload_mid_run();
        test_zero_start();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
